// File: rtl/sr_ff_monitor.sv
// sr_ff_monitor: response monitor for an SR flip-flop.
// Samples s/r and the flip-flop output q_dut on every rising edge and checks
// q_dut against an internal reference model. Flags mismatches and counts
// illegal s=r=1 commands. All statistics counters saturate.
//
// Build option: SRMON_SET_DOMINANT_EN
//   defined   : s=r=1 is a set-dominant command (q_exp<=1, model keeps tracking)
//   undefined : s=r=1 makes the model lose sync (back to UNSYNC)
//
// The reference-model state is visible on the synced output (1 = TRACK).
module sr_ff_monitor #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             s,
  input  logic             r,
  input  logic             q_dut,
  output logic             q_exp,
  output logic             synced,
  output logic             mismatch,
  output logic             err_sticky,
  output logic [CNT_W-1:0] err_count,
  output logic [CNT_W-1:0] chk_count,
  output logic [CNT_W-1:0] ill_count
);

  typedef enum logic {
    UNSYNC = 1'b0,
    TRACK  = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic             q_exp_q, q_exp_d;
  logic             mismatch_q, mismatch_d;
  logic             err_sticky_q, err_sticky_d;
  logic [CNT_W-1:0] err_count_q, err_count_d;
  logic [CNT_W-1:0] chk_count_q, chk_count_d;
  logic [CNT_W-1:0] ill_count_q, ill_count_d;

  // Decoded command; anything that is not a clean 00/10/01 (including an
  // unknown bit on s or r) is treated as the illegal s=r=1 command.
  logic cmd_set, cmd_reset, cmd_hold, cmd_ill, cmp_fail;

  // Saturating increment: stick at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  // Command decode and four-state compare of the flip-flop output.
  always_comb begin
    cmd_set   = (s === 1'b1) && (r === 1'b0);
    cmd_reset = (s === 1'b0) && (r === 1'b1);
    cmd_hold  = (s === 1'b0) && (r === 1'b0);
    cmd_ill   = !(cmd_set || cmd_reset || cmd_hold);
    cmp_fail  = (q_dut !== q_exp_q);
  end

  // Next-state, model update, compare result and statistics.
  always_comb begin
    state_d      = state_q;
    q_exp_d      = q_exp_q;
    mismatch_d   = 1'b0;
    err_sticky_d = err_sticky_q;
    err_count_d  = err_count_q;
    chk_count_d  = chk_count_q;
    ill_count_d  = ill_count_q;

    case (state_q)
      UNSYNC: begin
        // Only a clean set or reset tells us the flip-flop value; no compare.
        if (cmd_set) begin
          state_d = TRACK;
          q_exp_d = 1'b1;
        end else if (cmd_reset) begin
          state_d = TRACK;
          q_exp_d = 1'b0;
        end else if (cmd_ill) begin
`ifdef SRMON_SET_DOMINANT_EN
          state_d = TRACK;
          q_exp_d = 1'b1;
`else
          state_d = UNSYNC;
`endif
        end
      end
      TRACK: begin
        // Compare against the pre-update model value, then update the model.
        chk_count_d = sat_inc(chk_count_q);
        if (cmp_fail) begin
          mismatch_d   = 1'b1;
          err_sticky_d = 1'b1;
          err_count_d  = sat_inc(err_count_q);
        end
        if (cmd_set) begin
          q_exp_d = 1'b1;
        end else if (cmd_reset) begin
          q_exp_d = 1'b0;
        end else if (cmd_ill) begin
`ifdef SRMON_SET_DOMINANT_EN
          q_exp_d = 1'b1;
`else
          state_d = UNSYNC;
`endif
        end
      end
      default: state_d = UNSYNC;
    endcase

    if (cmd_ill) begin
      ill_count_d = sat_inc(ill_count_q);
    end

    // Clear wins over any same-edge count; mismatch still reports the edge.
    if (clr) begin
      err_sticky_d = 1'b0;
      err_count_d  = '0;
      chk_count_d  = '0;
      ill_count_d  = '0;
    end
  end

  // State and statistics registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= UNSYNC;
      q_exp_q      <= 1'b0;
      mismatch_q   <= 1'b0;
      err_sticky_q <= 1'b0;
      err_count_q  <= '0;
      chk_count_q  <= '0;
      ill_count_q  <= '0;
    end else begin
      state_q      <= state_d;
      q_exp_q      <= q_exp_d;
      mismatch_q   <= mismatch_d;
      err_sticky_q <= err_sticky_d;
      err_count_q  <= err_count_d;
      chk_count_q  <= chk_count_d;
      ill_count_q  <= ill_count_d;
    end
  end

  assign q_exp      = q_exp_q;
  assign synced     = (state_q == TRACK);
  assign mismatch   = mismatch_q;
  assign err_sticky = err_sticky_q;
  assign err_count  = err_count_q;
  assign chk_count  = chk_count_q;
  assign ill_count  = ill_count_q;

endmodule

// File: tb/tb_sr_ff_monitor.sv
// Testbench for sr_ff_monitor. Two instances (CNT_W=8 and CNT_W=2) share the
// same stimulus; a bench-side SR flip-flop produces q_dut, with optional
// fault injection, and a counting reference model provides expectations.
module tb_sr_ff_monitor;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic clr = 1'b0;
  logic s = 1'b0;
  logic r = 1'b0;
  logic q_dut = 1'b0;

  logic       a_qexp, a_sync, a_mm, a_stk;
  logic [7:0] a_err, a_chk, a_ill;
  logic       b_qexp, b_sync, b_mm, b_stk;
  logic [1:0] b_err, b_chk, b_ill;

  int tests = 0;
  int fails = 0;

  // Reference model: known flag, model value and raw event counts since clear.
  logic m_known = 1'b0;
  logic m_q = 1'b0;
  logic m_mm = 1'b0;
  logic m_sticky = 1'b0;
  int   m_err = 0;
  int   m_chk = 0;
  int   m_ill = 0;
  // Bench flip-flop state.
  logic ff_q = 1'b0;

  // clock
  always #5 clk = ~clk;

  sr_ff_monitor #(.CNT_W(8)) u_dut8 (
    .clk(clk), .rst(rst), .clr(clr), .s(s), .r(r), .q_dut(q_dut),
    .q_exp(a_qexp), .synced(a_sync), .mismatch(a_mm), .err_sticky(a_stk),
    .err_count(a_err), .chk_count(a_chk), .ill_count(a_ill)
  );

  sr_ff_monitor #(.CNT_W(2)) u_dut2 (
    .clk(clk), .rst(rst), .clr(clr), .s(s), .r(r), .q_dut(q_dut),
    .q_exp(b_qexp), .synced(b_sync), .mismatch(b_mm), .err_sticky(b_stk),
    .err_count(b_err), .chk_count(b_chk), .ill_count(b_ill)
  );

  function automatic int sat(input int v, input int w);
    int mx;
    mx = (1 << w) - 1;
    return (v > mx) ? mx : v;
  endfunction

  task automatic model_reset();
    m_known = 1'b0; m_q = 1'b0; m_mm = 1'b0; m_sticky = 1'b0;
    m_err = 0; m_chk = 0; m_ill = 0;
  endtask

  // One sampled edge of the monitor, described by its rules.
  task automatic model_step(input logic si, input logic ri, input logic ci, input logic qd);
    logic ill;
    ill = !(((si === 1'b0) && (ri === 1'b0)) || ((si ^ ri) === 1'b1));
    m_mm = 1'b0;
    if (m_known) begin
      m_chk++;
      if (qd !== m_q) begin
        m_mm = 1'b1; m_err++; m_sticky = 1'b1;
      end
      if (ill) begin
`ifdef SRMON_SET_DOMINANT_EN
        m_q = 1'b1;
`else
        m_known = 1'b0;
`endif
      end else if (si === 1'b1) m_q = 1'b1;
      else if (ri === 1'b1) m_q = 1'b0;
    end else if ((si ^ ri) === 1'b1) begin
      m_known = 1'b1; m_q = si;
    end
`ifdef SRMON_SET_DOMINANT_EN
    else if (ill) begin
      m_known = 1'b1; m_q = 1'b1;
    end
`endif
    if (ill) m_ill++;
    if (ci) begin
      m_err = 0; m_chk = 0; m_ill = 0; m_sticky = 1'b0;
    end
  endtask

  // Driver: one clock. fmode 0 = real flip-flop, 1 = force 0, 2 = force 1, 3 = force X.
  task automatic drive_cycle(input logic si, input logic ri, input logic ci, input int fmode);
    @(negedge clk);
    s = si; r = ri; clr = ci;
    case (fmode)
      1: q_dut = 1'b0;
      2: q_dut = 1'b1;
      3: q_dut = 1'bx;
      default: q_dut = ff_q;
    endcase
    model_step(si, ri, ci, q_dut);
    if (si === 1'b1 && ri === 1'b0) ff_q = 1'b1;
    else if (si === 1'b0 && ri === 1'b1) ff_q = 1'b0;
`ifdef SRMON_SET_DOMINANT_EN
    else if (si === 1'b1 && ri === 1'b1) ff_q = 1'b1;
`endif
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    #2;
    model_reset();
    @(negedge clk);
    rst = 1'b0; s = 1'b0; r = 1'b0; clr = 1'b0;
  endtask

  task automatic test_reset();
    #3;
    tests++;
    if ({a_qexp, a_sync, a_mm, a_stk} !== 4'b0000 || {a_err, a_chk, a_ill} !== 24'd0) begin
      fails++;
      $display("FAIL reset8: got q=%b sy=%b mm=%b st=%b e=%0d c=%0d i=%0d, want all 0",
               a_qexp, a_sync, a_mm, a_stk, a_err, a_chk, a_ill);
    end
    tests++;
    if ({b_qexp, b_sync, b_mm, b_stk} !== 4'b0000 || {b_err, b_chk, b_ill} !== 6'd0) begin
      fails++;
      $display("FAIL reset2: got q=%b sy=%b mm=%b st=%b e=%0d c=%0d i=%0d, want all 0",
               b_qexp, b_sync, b_mm, b_stk, b_err, b_chk, b_ill);
    end
    apply_reset();
  endtask

  // 00,10,01,11,00 with a correct flip-flop.
  task automatic test_sequence();
    logic [1:0] sr_seq [5];
    logic       exp_sync [5];
    sr_seq = '{2'b00, 2'b10, 2'b01, 2'b11, 2'b00};
`ifdef SRMON_SET_DOMINANT_EN
    exp_sync = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
`else
    exp_sync = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
`endif
    apply_reset();
    for (int i = 0; i < 5; i++) begin
      drive_cycle(sr_seq[i][1], sr_seq[i][0], 1'b0, 0);
      tests++;
      if (a_sync !== exp_sync[i]) begin
        fails++;
        $display("FAIL seq_synced[%0d]: got %b want %b", i, a_sync, exp_sync[i]);
      end
`ifdef SRMON_SET_DOMINANT_EN
      if (i == 3) begin
        tests++;
        if (a_qexp !== 1'b1) begin
          fails++;
          $display("FAIL seq_qexp_11: got %b want 1", a_qexp);
        end
      end
`endif
    end
    tests++;
    if (a_err !== 8'd0 || a_ill !== 8'd1) begin
      fails++;
      $display("FAIL seq_counts: got err=%0d ill=%0d want err=0 ill=1", a_err, a_ill);
    end
  endtask

  task automatic test_force_mismatch();
    drive_cycle(1'b1, 1'b0, 1'b1, 0);
    drive_cycle(1'b0, 1'b0, 1'b0, 1);
    tests++;
    if (a_mm !== 1'b1 || a_err !== 8'd1 || a_stk !== 1'b1 || a_chk !== 8'd1) begin
      fails++;
      $display("FAIL force_mm: got mm=%b err=%0d st=%b chk=%0d want 1,1,1,1",
               a_mm, a_err, a_stk, a_chk);
    end
    drive_cycle(1'b0, 1'b0, 1'b0, 0);
    tests++;
    if (a_mm !== 1'b0 || a_err !== 8'd1 || a_stk !== 1'b1) begin
      fails++;
      $display("FAIL force_mm_after: got mm=%b err=%0d st=%b want 0,1,1", a_mm, a_err, a_stk);
    end
  endtask

  task automatic test_x_qdut();
    drive_cycle(1'b1, 1'b0, 1'b1, 0);
    drive_cycle(1'b0, 1'b0, 1'b0, 3);
    tests++;
    if (a_mm !== m_mm || a_err !== 8'(sat(m_err, 8))) begin
      fails++;
      $display("FAIL x_qdut: got mm=%b err=%0d want mm=%b err=%0d", a_mm, a_err, m_mm, sat(m_err, 8));
    end
  endtask

  task automatic test_saturation();
    drive_cycle(1'b1, 1'b0, 1'b1, 0);
    for (int i = 0; i < 5; i++) begin
      drive_cycle(1'b0, 1'b0, 1'b0, 1);
      tests++;
      if (b_mm !== 1'b1 || a_mm !== 1'b1) begin
        fails++;
        $display("FAIL sat_pulse[%0d]: got mm2=%b mm8=%b want 1", i, b_mm, a_mm);
      end
    end
    tests++;
    if (b_err !== 2'd3 || b_stk !== 1'b1 || a_err !== 8'd5) begin
      fails++;
      $display("FAIL sat_count: got err2=%0d st2=%b err8=%0d want 3,1,5", b_err, b_stk, a_err);
    end
  endtask

  task automatic test_clr_collision();
    drive_cycle(1'b1, 1'b0, 1'b0, 0);
    drive_cycle(1'b0, 1'b0, 1'b1, 1);
    tests++;
    if (a_mm !== 1'b1 || a_err !== 8'd0 || a_stk !== 1'b0 || a_chk !== 8'd0) begin
      fails++;
      $display("FAIL clr_mm: got mm=%b err=%0d st=%b chk=%0d want 1,0,0,0", a_mm, a_err, a_stk, a_chk);
    end
    drive_cycle(1'b1, 1'b1, 1'b1, 0);
    tests++;
    if (a_ill !== 8'd0 || b_ill !== 2'd0) begin
      fails++;
      $display("FAIL clr_ill: got ill8=%0d ill2=%0d want 0", a_ill, b_ill);
    end
  endtask

  task automatic test_rst_mid();
    drive_cycle(1'b1, 1'b0, 1'b0, 0);
    drive_cycle(1'b1, 1'b1, 1'b0, 0);
    drive_cycle(1'b1, 1'b0, 1'b0, 0);
    drive_cycle(1'b0, 1'b0, 1'b0, 1);
    #2;
    rst = 1'b1;
    #1;
    tests++;
    if ({a_qexp, a_sync, a_mm, a_stk} !== 4'b0000 || {a_err, a_chk, a_ill} !== 24'd0) begin
      fails++;
      $display("FAIL rst_mid: got q=%b sy=%b mm=%b st=%b e=%0d c=%0d i=%0d, want all 0",
               a_qexp, a_sync, a_mm, a_stk, a_err, a_chk, a_ill);
    end
    apply_reset();
    drive_cycle(1'b0, 1'b0, 1'b0, 0);
    tests++;
    if (a_sync !== 1'b0 || a_chk !== 8'd0) begin
      fails++;
      $display("FAIL rst_release: got synced=%b chk=%0d want 0,0", a_sync, a_chk);
    end
  endtask

  task automatic test_random();
    logic si, ri, ci;
    int   fm;
    for (int n = 0; n < 400; n++) begin
      si = 1'($urandom_range(0, 1));
      ri = ($urandom_range(0, 3) == 0) ? si : 1'($urandom_range(0, 1));
      ci = ($urandom_range(0, 19) == 0);
      fm = ($urandom_range(0, 7) == 0) ? int'($urandom_range(1, 3)) : 0;
      drive_cycle(si, ri, ci, fm);
      tests++;
      if (a_sync !== m_known || a_mm !== m_mm || a_stk !== m_sticky ||
          (m_known && a_qexp !== m_q)) begin
        fails++;
        $display("FAIL rand8_flags[%0d]: got sy=%b mm=%b st=%b q=%b want sy=%b mm=%b st=%b q=%b",
                 n, a_sync, a_mm, a_stk, a_qexp, m_known, m_mm, m_sticky, m_q);
      end
      tests++;
      if (a_err !== 8'(sat(m_err, 8)) || a_chk !== 8'(sat(m_chk, 8)) || a_ill !== 8'(sat(m_ill, 8))) begin
        fails++;
        $display("FAIL rand8_counts[%0d]: got e=%0d c=%0d i=%0d want e=%0d c=%0d i=%0d",
                 n, a_err, a_chk, a_ill, sat(m_err, 8), sat(m_chk, 8), sat(m_ill, 8));
      end
      tests++;
      if (b_mm !== m_mm || b_stk !== m_sticky || b_err !== 2'(sat(m_err, 2)) ||
          b_chk !== 2'(sat(m_chk, 2)) || b_ill !== 2'(sat(m_ill, 2))) begin
        fails++;
        $display("FAIL rand2[%0d]: got mm=%b st=%b e=%0d c=%0d i=%0d want mm=%b st=%b e=%0d c=%0d i=%0d",
                 n, b_mm, b_stk, b_err, b_chk, b_ill, m_mm, m_sticky,
                 sat(m_err, 2), sat(m_chk, 2), sat(m_ill, 2));
      end
    end
  endtask

  initial begin
    test_reset();
    test_sequence();
    test_force_mismatch();
    test_x_qdut();
    test_saturation();
    test_clr_collision();
    test_rst_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
